// File: rtl/fir_pkg.sv
// Shared widths, default coefficients and FSM encoding for the time-multiplexed FIR.
// The FIR_COEF_WR_EN macro (used in fir_seq) selects writable coefficient registers.
package fir_pkg;
  localparam int SMP_W    = 12;  // Q2.10 sample
  localparam int COEF_W   = 10;  // Q0.10 coefficient
  localparam int PROD_W   = 22;  // Q2.20 product
  localparam int RES_W    = 12;  // Q2.10 result
  localparam int FRAC_W   = 10;
  localparam int RND_C    = 1 << (FRAC_W - 1);
  localparam int RES_MAX  = 2047;
  localparam int RES_MIN  = -2048;
  localparam int NTAP_MAX = 16;

  // Taps beyond the 8-tap default set are zero so larger NTAP builds stay defined.
  localparam logic signed [COEF_W-1:0] COEF_DEFAULT [NTAP_MAX] = '{
    10'sd21, 10'sd67, 10'sd170, 10'sd253, 10'sd253, 10'sd170, 10'sd67, 10'sd21,
    10'sd0,  10'sd0,  10'sd0,   10'sd0,   10'sd0,   10'sd0,   10'sd0,  10'sd0
  };

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fir_seq_if.sv
// Sample-in / result-out valid/ready handshake bundle for fir_seq.
interface fir_seq_if;
  import fir_pkg::*;

  logic                    in_valid;
  logic signed [SMP_W-1:0] in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [RES_W-1:0] out_data;
  logic                    out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/fir_mac.sv
// Shared multiply-accumulate with clear/enable plus round-and-saturate of the running sum.
module fir_mac
  import fir_pkg::*;
#(
  parameter int NTAP = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [SMP_W-1:0]  smp_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [RES_W-1:0]  res_o
);
  localparam int AW = PROD_W + idx_w(NTAP);
  localparam logic signed [AW:0] SAT_HI = (AW+1)'(RES_MAX);
  localparam logic signed [AW:0] SAT_LO = (AW+1)'(RES_MIN);

  logic signed [PROD_W-1:0] smp_x, coef_x, prod;
  logic signed [AW-1:0]     acc_q, acc_d, sum;
  logic signed [AW:0]       rnd, shf;

  assign smp_x  = PROD_W'(smp_i);
  assign coef_x = PROD_W'(coef_i);
  assign prod   = smp_x * coef_x;
  assign sum    = acc_q + AW'(prod);

  // Result is taken from the sum including the current product, so the
  // last tap's contribution is visible on the same edge it is accumulated.
  assign rnd = (AW+1)'(sum) + (AW+1)'(RND_C);
  assign shf = rnd >>> FRAC_W;

  always_comb begin
    if (shf > SAT_HI)      res_o = RES_W'(RES_MAX);
    else if (shf < SAT_LO) res_o = RES_W'(RES_MIN);
    else                   res_o = shf[RES_W-1:0];
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/fir_seq.sv
// Sequencer for the shared-MAC FIR: delay line, tap counter, coefficient store, handshakes.
// Define FIR_COEF_WR_EN to get writable coefficients and the coef_* ports.
module fir_seq
  import fir_pkg::*;
#(
  parameter int NTAP = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir_seq_if.slave                 io,
  output logic                     busy
`ifdef FIR_COEF_WR_EN
  ,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data
`endif
);
  localparam int KW = idx_w(NTAP);

  state_e                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [KW-1:0]                wp_q, wp_d;
  logic [KW-1:0]                base_q, base_d;
  logic [KW-1:0]                tap_idx;
  logic [NTAP-1:0][SMP_W-1:0]   dl_q;
  logic signed [RES_W-1:0]      out_q;
  logic signed [SMP_W-1:0]      smp_sel;
  logic signed [COEF_W-1:0]     coef_sel;
  logic signed [RES_W-1:0]      mac_res;
  logic                         dl_we, acc_clr, acc_en, out_ld;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wp_d    = wp_q;
    base_d  = base_q;
    dl_we   = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    out_ld  = 1'b0;
    unique case (state_q)
      IDLE: if (io.in_valid) begin
        dl_we   = 1'b1;
        base_d  = wp_q;
        wp_d    = wp_q + KW'(1);
        acc_clr = 1'b1;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_en = 1'b1;
        k_d    = k_q + KW'(1);
        if (k_q == KW'(NTAP - 1)) begin
          out_ld  = 1'b1;
          state_d = OUT;
        end
      end
      OUT: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      wp_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wp_q    <= wp_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dl_q <= '0;
    else if (dl_we) dl_q[wp_q] <= io.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_q <= '0;
    else if (out_ld) out_q <= mac_res;
  end

  // NTAP is a power of two, so the pointer subtraction wraps modulo NTAP for free.
  assign tap_idx = base_q - k_q;
  assign smp_sel = $signed(dl_q[tap_idx]);

`ifdef FIR_COEF_WR_EN
  logic [NTAP-1:0][COEF_W-1:0] coef_q;

  // Writes only land in IDLE so a filter pass never sees a mixed coefficient set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) coef_q[i] <= COEF_DEFAULT[i];
    end else if (state_q == IDLE && coef_we && 32'(coef_addr) < NTAP) begin
      coef_q[coef_addr[KW-1:0]] <= coef_data;
    end
  end

  assign coef_sel = $signed(coef_q[k_q]);
`else
  assign coef_sel = COEF_DEFAULT[k_q];
`endif

  fir_mac #(.NTAP(NTAP)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .smp_i  (smp_sel),
    .coef_i (coef_sel),
    .res_o  (mac_res)
  );

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == OUT);
  assign io.out_data  = out_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_fir_seq.sv
// Directed + randomized bench for fir_seq against an arithmetic convolution model.
module tb_fir_seq;
  import fir_pkg::*;

  localparam int NTAP  = 8;
  localparam int CLK_P = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef FIR_COEF_WR_EN
  logic                     coef_we = 1'b0;
  logic [3:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
`endif

  fir_seq_if v();

  fir_seq #(.NTAP(NTAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (v),
    .busy  (busy)
`ifdef FIR_COEF_WR_EN
    ,
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
`endif
  );

  always #(CLK_P/2) clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int hist [NTAP];
  int cm   [NTAP];
  bit mac_wr = 1'b0;
  int got;
  int imp  [9]  = '{21, 67, 170, 253, 253, 170, 67, 21, 0};
  int rs   [25];
  int bp   [7];

  task automatic chk(input string tag, input integer obs, input integer exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: direct convolution of the last NTAP accepted samples.
  function automatic int model_out();
    longint s = 0;
    longint r;
    for (int k = 0; k < NTAP; k++) s += longint'(hist[k]) * longint'(cm[k]);
    r = (s + 512) >>> 10;
    if (r > 2047) r = 2047;
    else if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NTAP; k++) begin
      hist[k] = 0;
      cm[k]   = int'(COEF_DEFAULT[k]);
    end
  endtask

  task automatic push(input int x);
    for (int k = NTAP - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endtask

  task automatic do_reset();
    @(negedge clk);
    v.in_valid = 1'b0; v.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  v.in_ready,  1);
    chk("rst_out_valid", v.out_valid, 0);
    chk("rst_out_data",  v.out_data,  0);
    chk("rst_busy",      busy,        0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction: offer x, check MAC timing, optionally stall OUT while offering nx.
  task automatic run_sample(input int x, input int stall, input int nx, output int res);
    int n;
    int exp;
    integer held;
    v.out_ready = (stall == 0);
    v.in_valid  = 1'b1;
    v.in_data   = 12'(x);
    n = 0;
    while (!v.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", v.in_ready, 1);
    @(posedge clk);
    push(x);
    exp = model_out();
    #1 v.in_valid = 1'b0;
    for (int j = 0; j < NTAP; j++) begin
      @(negedge clk);
`ifdef FIR_COEF_WR_EN
      if (mac_wr) begin
        coef_we = (j == 1); coef_addr = 4'd7; coef_data = 10'sd100;
      end
`endif
      chk("mac_flags", {v.out_valid, v.in_ready, busy}, 3'b001);
    end
`ifdef FIR_COEF_WR_EN
    coef_we = 1'b0;
`endif
    @(negedge clk);
    chk("out_valid", v.out_valid, 1);
    res = int'(v.out_data);
    chk("out_data", res, exp);
    held = v.out_data;
    for (int s = 0; s < stall; s++) begin
      v.in_valid = 1'b1;
      v.in_data  = 12'(nx);
      @(negedge clk);
      chk("bp_flags", {v.out_valid, v.in_ready}, 2'b10);
      chk("bp_hold",  v.out_data, held);
    end
    v.out_ready = 1'b1;
    @(posedge clk);
    #1 v.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_flags", {v.out_valid, v.in_ready, busy}, 3'b010);
    chk("out_hold",   v.out_data, held);
  endtask

`ifdef FIR_COEF_WR_EN
  task automatic wr_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 4'(a); coef_data = 10'(d);
    @(posedge clk);
    #1 coef_we = 1'b0;
    if (a < NTAP) cm[a] = d;
    @(negedge clk);
  endtask
`endif

  initial begin
    #(CLK_P * 50000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    v.in_valid = 1'b0; v.in_data = '0; v.out_ready = 1'b1;
    model_reset();
    do_reset();

    for (int i = 0; i < 9; i++) begin
      run_sample((i == 0) ? 1024 : 0, 0, 0, got);
      chk("impulse", got, imp[i]);
    end
    for (int i = 0; i < 16; i++) begin
      run_sample(1024, 0, 0, got);
      if (i >= 7) chk("dc_pos", got, 1022);
    end
    for (int i = 0; i < 16; i++) begin
      run_sample(-2048, 0, 0, got);
      if (i >= 7) chk("dc_neg", got, -2044);
    end

    for (int i = 0; i < 7; i++) bp[i] = int'($urandom_range(0, 4095)) - 2048;
    for (int i = 0; i < 6; i++) run_sample(bp[i], 5, bp[i+1], got);

    for (int i = 0; i < 25; i++) rs[i] = int'($urandom_range(0, 4095)) - 2048;
    for (int i = 0; i < 24; i++) run_sample(rs[i], int'($urandom_range(0, 3)), rs[i+1], got);

    // Reset while k = 4: outputs drop back at once and the delay line is cleared.
    v.in_valid = 1'b1; v.in_data = 12'sd1024;
    @(posedge clk);
    #1 v.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmac_in_ready",  v.in_ready,  1);
    chk("midmac_out_valid", v.out_valid, 0);
    chk("midmac_out_data",  v.out_data,  0);
    chk("midmac_busy",      busy,        0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      run_sample((i == 0) ? 1024 : 0, 0, 0, got);
      chk("impulse_after_rst", got, imp[i]);
    end

`ifdef FIR_COEF_WR_EN
    do_reset();
    wr_coef(9, 0);
    mac_wr = 1'b1;
    run_sample(1024, 0, 0, got);
    mac_wr = 1'b0;
    chk("wr_in_mac_t0", got, imp[0]);
    for (int i = 1; i < 9; i++) begin
      run_sample(0, 0, 0, got);
      chk("wr_in_mac", got, imp[i]);
    end
    for (int a = 0; a < NTAP; a++) wr_coef(a, 511);
    for (int i = 0; i < NTAP; i++) run_sample(2047, 0, 0, got);
    chk("sat_pos", got, 2047);
    for (int i = 0; i < NTAP; i++) run_sample(-2048, 0, 0, got);
    chk("sat_neg", got, -2048);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fir_seq.md
# fir_seq

Time-multiplexed 8-tap FIR engine with sequencer. It replaces the fully parallel 8-multiplier filter in the backend with one shared multiply-accumulate unit that a small state machine steps across the taps. Samples enter and results leave over valid/ready handshakes, so the block sits between the sample source and the de-emphasis output stage without a free-running sample rate. Arithmetic formats match the parallel filter: Q2.10 samples, Q0.10 coefficients, Q2.20 products, and a rounded Q2.10 result.

## Interface
- `NTAP`, default 8: number of taps. It must be a power of two, at most 16.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: a sample is offered.
- `in_data`, input, 12: signed sample, Q2.10.
- `in_ready`, output, 1: the block accepts the sample in this cycle.
- `out_valid`, output, 1: a result is available.
- `out_data`, output, 12: signed result, Q2.10.
- `out_ready`, input, 1: the consumer takes the result in this cycle.
- `busy`, output, 1: the state is not IDLE.
- `coef_we`, input, 1: coefficient write strobe. Present only with `FIR_COEF_WR_EN`.
- `coef_addr`, input, 4: tap index to write. Present only with `FIR_COEF_WR_EN`.
- `coef_data`, input, 10: signed coefficient, Q0.10. Present only with `FIR_COEF_WR_EN`.

## Operation
- Delay line: a circular buffer of NTAP 12-bit entries with write pointer `wp`.
  - An accepted sample is written at `wp`, then `wp` increments modulo NTAP.
  - Tap k reads entry `(wp_at_accept − k) mod NTAP`. Tap 0 is the newest sample.
- Coefficients: default set {21, 67, 170, 253, 253, 170, 67, 21} (Q0.10) for taps 0..7.
- State machine:
  - IDLE: `in_ready` = 1. On `in_valid`, write the sample, clear the accumulator, set tap counter k = 0, go to MAC.
  - MAC: each cycle add `sample[k] * coef[k]` (22-bit signed) into the accumulator, then increment k. After tap NTAP−1, go to OUT.
  - OUT: `out_valid` = 1 and `out_data` is held. On `out_ready`, go to IDLE.
- Accumulator width: 22 + log2(NTAP) bits, signed. It never wraps.
- Rounding and saturation:
  - Rounding adds 2^9, then arithmetic-shifts right by 10.
  - The shifted value is saturated to [−2048, 2047].
  - The result is registered into `out_data` on the MAC→OUT edge.
- `in_ready` is 0 in MAC and OUT. No sample is dropped and none is buffered beyond the delay line.
- `out_data` holds its last value outside OUT.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_data` 0, `busy` 0, all delay-line entries 0, `wp` 0, accumulator 0. Coefficients return to the default set.
- Latency: a sample accepted at edge E produces `out_valid` = 1 after edge E+NTAP (MAC occupies edges E+1..E+NTAP).
- Throughput with `out_ready` tied high: one sample every NTAP+2 cycles (10 cycles for NTAP = 8).
- Backpressure: while `out_ready` = 0 in OUT, `out_valid` and `out_data` stay stable and `in_ready` stays 0.
- `in_valid` outside IDLE is ignored. The upstream holds it until it sees `in_ready`.
- Asserting `rst_n` low in any state, including mid-MAC, restores all reset values immediately. A partial accumulation is discarded.

## Configuration
- `FIR_COEF_WR_EN` defined:
  - The coefficients are NTAP writable 10-bit registers, loaded with the default set on reset.
  - The `coef_*` ports exist. A write takes effect at the edge where `coef_we` = 1, but only in IDLE.
  - Writes in MAC or OUT are dropped, so software polls `busy`.
  - `coef_addr` ≥ NTAP is ignored.
- `FIR_COEF_WR_EN` not defined:
  - The coefficients are constants from the package.
  - The `coef_*` ports are absent.
  - Saturation logic stays in place.

## Structure
- Package `fir_pkg` holds:
  - sample, coefficient, product and result widths;
  - the default coefficient array;
  - the state enum {IDLE, MAC, OUT};
  - the rounding constant (2^9).
- Sub-module `fir_mac` holds the multiplier, accumulator with clear/enable, and the round-and-saturate output. It has no control state.
- `fir_seq` holds the FSM, tap counter, delay line, coefficient store and handshakes.

## Test plan
- Impulse: send 1024 followed by 8 zeros, `out_ready` = 1. Results are 21, 67, 170, 253, 253, 170, 67, 21, then 0.
- DC: send constant 1024 for 16 samples. From the 8th result on, every result is 1022. Constant −2048 settles to −2044.
- Backpressure: hold `out_ready` = 0 for 5 cycles in OUT. `out_data` is stable, `in_ready` = 0, the offered `in_valid` is not consumed until after the handshake, and the result sequence is unchanged.
- Reset mid-MAC: deassert `rst_n` at tap 4. Outputs return to reset values at once. A following impulse reproduces the impulse response exactly, confirming the delay line was cleared.
- With `FIR_COEF_WR_EN`, saturation: write all taps to 511 in IDLE, then feed 2047 ×8. Results are 2047 (saturated). −2048 ×8 gives −2048.
- With `FIR_COEF_WR_EN`, write attempt during MAC: the write is dropped and the coefficients read back unchanged; the impulse response still matches the default set.
